// File: rtl/sqrt_pkg.sv
// Shared types and helpers for the handshaked square-root unit.
// Optional feature macro: SQRT_ROUND_EN (round-to-nearest root).
package sqrt_pkg;

  // Default operand width.
  localparam int unsigned N_DEF = 28;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Root width derived from the operand width.
  function automatic int unsigned root_width(input int unsigned n);
    return n / 2;
  endfunction

  // Operand width must be even and at least 4.
  function automatic bit n_legal(input int unsigned n);
    return ((n % 2) == 0) && (n >= 4);
  endfunction

endpackage

// File: rtl/sqrt_unit_hs_if.sv
// Start/busy/done handshake bundle between the operation decoder and the sqrt unit.
interface sqrt_unit_hs_if
  import sqrt_pkg::*;
#(
  parameter int unsigned N = N_DEF
) ();

  localparam int unsigned RW = root_width(N);

  logic          start;
  logic          signed_mode;
  logic [N-1:0]  num_in;
  logic          busy;
  logic          done;
  logic [RW-1:0] sq_root;
  logic [RW:0]   remainder;
  logic          eroare;

  modport master (
    output start, signed_mode, num_in,
    input  busy, done, sq_root, remainder, eroare
  );

  modport slave (
    input  start, signed_mode, num_in,
    output busy, done, sq_root, remainder, eroare
  );

endinterface

// File: rtl/sqrt_step.sv
// One non-restoring square-root stage: retires one root bit from a two-bit radicand slice.
module sqrt_step #(
  parameter int unsigned RW = 14
) (
  input  logic [RW+1:0] r,
  input  logic [RW-1:0] q,
  input  logic [1:0]    a2,
  output logic [RW+1:0] r_nxt_c,
  output logic          q_bit_c
);

  logic [RW+1:0] left;
  logic [RW+1:0] right;

  // Add when the partial remainder is negative, subtract otherwise.
  always_comb begin
    left    = {r[RW-1:0], a2};
    right   = {q, r[RW+1], 1'b1};
    r_nxt_c = r[RW+1] ? (left + right) : (left - right);
    q_bit_c = ~r_nxt_c[RW+1];
  end

endmodule

// File: rtl/sqrt_unit_hs.sv
// Iterative non-restoring integer square root with start/busy/done handshake.
// Optional feature macro: SQRT_ROUND_EN (sq_root rounded to nearest, saturating).
module sqrt_unit_hs
  import sqrt_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic           Clock,
  input  logic           reset,
  sqrt_unit_hs_if.slave  bus
);

  localparam int unsigned RW      = root_width(N);
  localparam int unsigned CW      = $clog2(RW + 1);
  localparam bit          N_LEGAL = n_legal(N);

  // Reject odd or too-narrow operand widths at elaboration.
  if (!N_LEGAL) begin : g_bad_n
    $error("sqrt_unit_hs: N must be even and >= 4");
  end

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [RW+1:0] r_q, r_d;
  logic [RW-1:0] q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [RW-1:0] root_q, root_d;
  logic [RW:0]   rem_q, rem_d;
  logic          eroare_q, eroare_d;

  logic [RW+1:0] step_r_c;
  logic          step_q_c;
  logic [RW+1:0] rem_full_c;
  logic [RW:0]   rem_fix_c;
  logic [RW-1:0] root_fin_c;

  sqrt_step #(.RW(RW)) u_step (
    .r       (r_q),
    .q       (q_q),
    .a2      (a_q[N-1:N-2]),
    .r_nxt_c (step_r_c),
    .q_bit_c (step_q_c)
  );

  // Final remainder correction and optional rounding of the root.
  always_comb begin
    rem_full_c = r_q[RW+1] ? (r_q + (RW+2)'({q_q, 1'b1})) : r_q;
    rem_fix_c  = rem_full_c[RW:0];
    root_fin_c = q_q;
`ifdef SQRT_ROUND_EN
    if ((rem_fix_c > (RW+1)'(q_q)) && (q_q != '1)) begin
      root_fin_c = q_q + RW'(1);
    end
`endif
  end

  // Next-state and next-register logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    r_d      = r_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    root_d   = root_q;
    rem_d    = rem_q;
    eroare_d = eroare_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          busy_d = 1'b1;
          if (bus.signed_mode && bus.num_in[N-1]) begin
            err_d   = 1'b1;
            state_d = FINISH;
          end else begin
            a_d      = bus.num_in;
            r_d      = '0;
            q_d      = '0;
            cnt_d    = '0;
            err_d    = 1'b0;
            eroare_d = 1'b0;
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        r_d   = step_r_c;
        q_d   = {q_q[RW-2:0], step_q_c};
        a_d   = a_q << 2;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(RW - 1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (err_q) begin
          root_d   = '0;
          rem_d    = '0;
          eroare_d = 1'b1;
          err_d    = 1'b0;
        end else begin
          root_d   = root_fin_c;
          rem_d    = rem_fix_c;
          eroare_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      r_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      root_q   <= '0;
      rem_q    <= '0;
      eroare_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      r_q      <= r_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      root_q   <= root_d;
      rem_q    <= rem_d;
      eroare_q <= eroare_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sq_root   = root_q;
  assign bus.remainder = rem_q;
  assign bus.eroare    = eroare_q;

endmodule

// File: tb/tb_sqrt_unit_hs.sv
// Self-checking bench for sqrt_unit_hs (N=28): vector table, corner sequences, random ops.
module tb_sqrt_unit_hs;

  localparam int unsigned N  = 28;
  localparam int unsigned RW = 14;
  localparam int          LAT_OK = RW + 1;
  localparam int          MAX_WAIT = 40;

  logic clk;
  logic reset;

  sqrt_unit_hs_if #(.N(N)) bus ();

  sqrt_unit_hs #(.N(N)) dut (
    .Clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic          sm;
    logic [N-1:0]  num;
    logic [RW-1:0] exp_root;
    logic [RW:0]   exp_rem;
    logic          exp_err;
    int            exp_lat;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact integer square root by search, independent of the hardware recurrence.
  function automatic void model(input logic sm, input logic [N-1:0] n,
                                output logic [RW-1:0] root, output logic [RW:0] rem,
                                output logic err);
    longint lo, hi, mid, val;
    if (sm && n[N-1]) begin
      root = '0;
      rem  = '0;
      err  = 1'b1;
    end else begin
      val = longint'(n);
      lo  = 0;
      hi  = 64'd1 << RW;
      while (lo < hi) begin
        mid = (lo + hi + 1) / 2;
        if (mid * mid <= val) lo = mid;
        else hi = mid - 1;
      end
      rem  = (RW+1)'(val - lo * lo);
      root = RW'(lo);
`ifdef SQRT_ROUND_EN
      if ((longint'(rem) > lo) && (lo < ((64'd1 << RW) - 1))) root = RW'(lo + 1);
`endif
      err = 1'b0;
    end
  endfunction

  // Issue one start and collect the response; optional extra start pulses at given clocks.
  task automatic run_op(input logic sm, input logic [N-1:0] num,
                        input int poke1, input int poke2, input logic [N-1:0] poke_num,
                        output int lat, output int busy_n,
                        output logic [RW-1:0] root, output logic [RW:0] rem, output logic err,
                        output logic busy_at_done, output logic done_next,
                        output logic [RW-1:0] root_next);
    @(posedge clk);
    #1;
    bus.start       = 1'b1;
    bus.signed_mode = sm;
    bus.num_in      = num;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat       = 0;
    busy_n    = 0;
    while (lat < MAX_WAIT) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.done) break;
      if (bus.busy) busy_n++;
      if ((lat + 1 == poke1) || (lat + 1 == poke2)) begin
        bus.start  = 1'b1;
        bus.num_in = poke_num;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start    = 1'b0;
    root         = bus.sq_root;
    rem          = bus.remainder;
    err          = bus.eroare;
    busy_at_done = bus.busy;
    @(posedge clk);
    #1;
    done_next = bus.done;
    root_next = bus.sq_root;
  endtask

  task automatic op_and_check(input string tag, input vec_t v, input int poke1, input int poke2,
                              input logic [N-1:0] poke_num);
    int lat, busy_n;
    logic [RW-1:0] root, root_next;
    logic [RW:0] rem;
    logic err, busy_at_done, done_next;
    run_op(v.sm, v.num, poke1, poke2, poke_num, lat, busy_n, root, rem, err,
           busy_at_done, done_next, root_next);
    check({tag, ".latency"}, lat, v.exp_lat);
    if (lat >= MAX_WAIT) return;
    check({tag, ".sq_root"}, root, v.exp_root);
    check({tag, ".remainder"}, rem, v.exp_rem);
    check({tag, ".eroare"}, err, v.exp_err);
    check({tag, ".busy_cycles"}, busy_n, v.exp_lat - 1);
    check({tag, ".busy_at_done"}, busy_at_done, 0);
    check({tag, ".done_width"}, done_next, 0);
    check({tag, ".root_hold"}, root_next, v.exp_root);
  endtask

  function automatic vec_t mk(input logic sm, input logic [N-1:0] num);
    vec_t v;
    v.sm  = sm;
    v.num = num;
    model(sm, num, v.exp_root, v.exp_rem, v.exp_err);
    v.exp_lat = v.exp_err ? 1 : LAT_OK;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    vec_t v;
    int dn;
    logic [RW-1:0] r157;

`ifdef SQRT_ROUND_EN
    r157 = 14'd13;
`else
    r157 = 14'd12;
`endif

    // Hand-derived expectations from the arithmetic, plus model-filled extras.
    vecs.push_back('{1'b0, 28'd144,       14'd12,    15'd0,     1'b0, LAT_OK});
    vecs.push_back('{1'b0, 28'hFFFFFFF,   14'd16383, 15'd32766, 1'b0, LAT_OK});
    vecs.push_back('{1'b1, 28'hFFFFFFB,   14'd0,     15'd0,     1'b1, 1});
    vecs.push_back('{1'b0, 28'd0,         14'd0,     15'd0,     1'b0, LAT_OK});
    vecs.push_back('{1'b0, 28'd157,       r157,      15'd13,    1'b0, LAT_OK});
    vecs.push_back('{1'b0, 28'd156,       14'd12,    15'd12,    1'b0, LAT_OK});
    vecs.push_back('{1'b0, 28'd81,        14'd9,     15'd0,     1'b0, LAT_OK});
    vecs.push_back(mk(1'b0, 28'h8000000));
    vecs.push_back(mk(1'b1, 28'h7FFFFFF));
    vecs.push_back(mk(1'b0, 28'd1));
    vecs.push_back(mk(1'b0, 28'd2));
    vecs.push_back(mk(1'b0, 28'd3));

    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.num_in      = '0;
    reset           = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", bus.busy, 0);
    check("reset.done", bus.done, 0);
    check("reset.sq_root", bus.sq_root, 0);
    check("reset.remainder", bus.remainder, 0);
    check("reset.eroare", bus.eroare, 0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      op_and_check($sformatf("vec%0d", i), vecs[i], -1, -1, '0);
    end

    // Start pulses during CALC are ignored; the original operand's result is returned.
    v = '{1'b0, 28'd144, 14'd12, 15'd0, 1'b0, LAT_OK};
    op_and_check("ignore_busy_start", v, 3, 10, 28'd400);
    v = '{1'b0, 28'd400, 14'd20, 15'd0, 1'b0, LAT_OK};
    op_and_check("after_ignore", v, -1, -1, '0);

    // Reset mid-operation clears outputs and aborts without a done pulse.
    @(posedge clk);
    #1;
    bus.start       = 1'b1;
    bus.signed_mode = 1'b0;
    bus.num_in      = 28'd144;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midreset.busy", bus.busy, 0);
    check("midreset.done", bus.done, 0);
    check("midreset.sq_root", bus.sq_root, 0);
    check("midreset.remainder", bus.remainder, 0);
    check("midreset.eroare", bus.eroare, 0);
    reset = 1'b1;
    dn = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dn++;
    end
    check("midreset.no_activity", dn, 0);
    v = '{1'b0, 28'd81, 14'd9, 15'd0, 1'b0, LAT_OK};
    op_and_check("after_reset", v, -1, -1, '0);

    // Random operands in both modes against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic sm;
      logic [N-1:0] num;
      sm  = 1'($urandom_range(0, 1));
      num = N'($urandom());
      if (i % 4 == 0) num = N'($urandom_range(0, 5000));
      op_and_check($sformatf("rnd%0d", i), mk(sm, num), -1, -1, '0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sqrt_unit_hs.md
Name: sqrt_unit_hs

Overview:
- Parametrised non-restoring integer square-root unit with an explicit start/busy/done handshake, remainder output and a runtime signed/unsigned mode.
- Successor to the calculator's fixed free-running square-root block.
- Sits behind the calculator operation decoder; one result per accepted start, iterating one root bit per clock.

Parameters:
- N, 28, operand width; must be even and >= 4.
- RW, N/2, root width (derived, not overridden).

Ports:
- Clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = num_in is two's complement; 0 = unsigned.
- num_in  in  N  radicand; captured on the accepted start edge.
- busy  out  1  high while an operation is in flight.
- done  out  1  single-cycle pulse when results are valid.
- sq_root  out  RW  floor(sqrt(num_in)), or rounded when the optional feature is enabled.
- remainder  out  RW+1  num_in - floor_root^2.
- eroare  out  1  high with done when a negative operand is given in signed mode.

Behaviour:
- Reset (reset=0 at a rising edge):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Internal a, r and q registers are cleared.
  - This applies in any state, so reset mid-operation aborts the operation with no done pulse.
- FSM states: IDLE, CALC, FINISH.
- IDLE:
  - start=1 with a legal operand: capture num_in, clear r/q, set iteration counter to 0, busy<=1, eroare<=0, go to CALC.
  - start=1 with signed_mode=1 and num_in[N-1]=1: go directly to FINISH with the error flag set; no iterations are run.
- CALC:
  - One non-restoring step per cycle.
  - left = {r[RW-1:0], a[N-1:N-2]}; right = {q, r[RW+1], 1'b1}.
  - r = r[RW+1] ? left+right : left-right.
  - q = {q[RW-2:0], ~r[RW+1]}; a shifts left by 2.
  - r is RW+2 bits signed.
  - After RW steps, go to FINISH.
- FINISH (one cycle):
  - done<=1 and busy<=0.
  - sq_root<=q.
  - remainder <= r negative ? r + {q,1'b1} : r, truncated to RW+1 bits.
  - On error: sq_root=0, remainder=0, eroare=1.
  - Return to IDLE.
- Latency:
  - Legal operand: done rises exactly RW+1 clocks after the start edge (N=28 gives 15).
  - Error case: 1 clock.
- done lasts one cycle. sq_root, remainder and eroare hold until the next FINISH or reset.
- start while busy (CALC or FINISH) is ignored and not queued. start in the same cycle done is high is accepted only from IDLE, so the earliest back-to-back start is the cycle after done.
- In unsigned mode, num_in[N-1]=1 is a legal large value.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: SQRT_ROUND_EN.
- Defined:
  - sq_root is rounded to nearest: floor_root+1 when remainder > floor_root, else floor_root.
  - If floor_root is all ones and would round up, it saturates at all ones.
  - remainder always reports the floor-based value.
  - Latency is unchanged (compare and increment are done in FINISH).
- Undefined: sq_root is the pure floor value; the rounding logic is absent.

Decomposition:
- Package sqrt_pkg holds:
  - the state enum (IDLE/CALC/FINISH);
  - the RW derivation helper;
  - a localparam checking that N is even (elaboration error otherwise).
- One sub-module, sqrt_step: a combinational single non-restoring add/sub stage with inputs r, q and a two-bit slice, and outputs next r and next q bit. It is instanced once and reused each cycle.

Test Plan:
- N=28, unsigned, num_in=144, start pulse -> done after 15 clocks; sq_root=12, remainder=0, eroare=0; busy high for cycles 1..14.
- Unsigned num_in=2^28-1 -> sq_root=16383, remainder=32766. With SQRT_ROUND_EN: sq_root=16383 (saturated).
- Signed mode, num_in=-5 -> done and eroare high 1 clock after start; sq_root=0, remainder=0; then an unsigned start with num_in=0 -> sq_root=0, eroare cleared.
- num_in=157 -> floor 12, remainder 13; with SQRT_ROUND_EN sq_root=13; num_in=156 -> 12 in both builds.
- start pulsed again at clocks 3 and 10 of a 144 operation with num_in=400 -> ignored; result 12; next start after done with 400 -> 20.
- reset=0 at clock 7 of an operation -> all outputs 0 next edge, no done pulse; a fresh start of 81 gives 9 with full latency.
